codebook_fetch_arbiter: RTL and testbench
=========================================

// Module: codebook_fetch_arbiter
// PURPOSE
//  Sequences 256-word VQ codebook fills for codebook_cache and shares the single VRAM read port
//  with the texel fetch path. Bursts reads for the codebook fill, interleaves texel requests fairly,
//  and routes in-order VRAM return data to the correct requester.
//  Sits between codebook_cache / texel fetch and the VRAM read arbiter.
// PARAMETERS
//  BURST_LEN  8   64-bit words per codebook VRAM burst; power of 2, 1..16, divides 256
//  MAX_OUT    4   max bursts/texel reads outstanding at VRAM; depth of the owner FIFO
// PORTS
//  clock       in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  cb_wait     in   1   codebook_cache codebook_wait; high while the fill is in progress
//  cb_base     in   23  VRAM byte address of the codebook; [2:0] ignored
//  cb_valid    out  1   to codebook_cache vram_valid; one pulse per codebook word
//  cb_dout     out  64  to codebook_cache cache_din
//  tex_req     in   1   texel read request; held until tex_ack
//  tex_addr    in   23  texel word byte address; [2:0] ignored
//  tex_ack     out  1   one-cycle pulse: tex_req issued to VRAM
//  tex_valid   out  1   texel return data valid
//  tex_dout    out  64  texel return data
//  vram_rd     out  1   VRAM read request; held with addr/len until !vram_busy
//  vram_addr   out  23  VRAM byte address, [2:0]=0
//  vram_len    out  5   words in this request (BURST_LEN or 1)
//  vram_busy   in   1   VRAM cannot accept; request is taken on a cycle with vram_rd && !vram_busy
//  vram_valid  in   1   one returned word, strictly in request order
//  vram_din    in   64  returned word
//  busy        out  1   fill active or any request outstanding
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; cb_issued=0; owner FIFO empty; beat counter 0.
//  - Rising edge of cb_wait (registered copy) arms a fill: cb_issued<=0. Arming is deferred
//    until no CB-owned entry remains in the FIFO.
//  - Issue FSM: IDLE -> CB_ISSUE | TEX_ISSUE; leave on acceptance (vram_rd && !vram_busy).
//    * CB_ISSUE: vram_addr = {cb_base[22:3],3'b0} + {cb_issued,3'b0}, vram_len = BURST_LEN;
//      on accept cb_issued += BURST_LEN. 9-bit counter; fill issue ends at 256.
//    * TEX_ISSUE: vram_addr = {tex_addr[22:3],3'b0}, vram_len = 1; tex_ack pulses on accept.
//    * Selection from IDLE: the FIFO must be non-full, else stay IDLE. If both requesters are
//      pending, choose tex when the last accepted request was CB, else CB. Single requester wins.
//    * vram_rd is registered, asserted the cycle after selection. Address and len stay stable
//      while vram_busy. There is never more than one request per acceptance.
//  - Each accept pushes {owner, len} into the owner FIFO. Each vram_valid beat goes to the head
//    owner: CB -> cb_valid/cb_dout, TEX -> tex_valid/tex_dout, registered (1-cycle latency).
//    The head pops after len beats.
//  - CB beats arriving while cb_wait is low are dropped (cb_valid stays 0), still counted.
//  - vram_valid with FIFO empty: beat is dropped; no state change.
//  - Simultaneous push and pop on a full FIFO: allowed (pop first), occupancy unchanged.
//  - cb_base and tex_addr are sampled at selection. cb_base must be stable for the whole fill.
//  - busy = cb fill armed and cb_issued<256, or FIFO non-empty, or vram_rd high.
//  - Reset mid-operation: everything clears asynchronously. Words still in flight from VRAM
//    then return to an empty FIFO and are dropped.
// STRUCTURE
//  - pvr_vram_pkg: VRAM_AW=23, VRAM_DW=64, owner_t {OWN_CB, OWN_TEX},
//    arb_state_t {IDLE, CB_ISSUE, TEX_ISSUE}.
//  - One sub-module: vram_owner_fifo. Sync FIFO, depth MAX_OUT, width 1+5, async active-high
//    reset, full/empty flags, same-cycle push/pop.
//  - Top: FSM, cb_issued counter, cb_wait edge detect, beat counter, return mux.
// TESTING
//  1. cb_base=0x100000, BURST_LEN=8, VRAM 2-cycle latency, no busy -> 32 requests at
//     0x100000, 0x100040 .. 0x1007C0, len 8. Exactly 256 cb_valid pulses with data in order.
//     busy falls after the last beat.
//  2. tex_req with addr 0x002008 during a fill -> issued right after the current CB burst with
//     vram_addr 0x002008 and len 1. One tex_ack and one tex_valid. Still 256 CB beats, in order.
//  3. vram_busy held 10 cycles with vram_rd pending -> vram_rd/addr/len stable. Exactly one
//     accept, no duplicate FIFO entry.
//  4. MAX_OUT=4, vram_valid withheld -> 4 accepts then vram_rd stays 0. The first returned
//     burst completing its 8th beat allows the 5th request next cycle.
//  5. Assert reset at the 100th CB beat -> all outputs 0 and FIFO empty immediately.
//     vram_valid beats after reset are dropped, no cb_valid. A new cb_wait edge restarts at
//     word 0 / cb_base.
//  6. tex_req only, alternating addresses 0x0 and 0x7FFFF8 -> each issued len 1. Returns are
//     routed only to tex_valid, cb_valid never asserts.

Source files
------------

// File: rtl/pvr_vram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pvr_vram_pkg
// Brief    : Shared VRAM widths, owner tags and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package pvr_vram_pkg;

    localparam int VRAM_AW  = 23;
    localparam int VRAM_DW  = 64;
    localparam int LEN_W    = 5;
    localparam int CB_WORDS = 256;

    typedef enum logic {
        OWN_CB  = 1'b0,
        OWN_TEX = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CB_ISSUE  = 2'd1,
        TEX_ISSUE = 2'd2
    } arb_state_t;

    typedef struct packed {
        owner_t           owner;
        logic [LEN_W-1:0] len;
    } owner_entry_t;

endpackage
`default_nettype wire

// File: rtl/vram_owner_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vram_owner_fifo
// Brief    : Sync FIFO of {owner, len} per outstanding VRAM request.
// Revision : 1.0
// ============================================================================
module vram_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/codebook_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : codebook_fetch_arbiter
// Brief    : Bursts 256-word codebook fills, interleaves texel reads on the
//            shared VRAM read port and routes in-order returns by owner.
// Revision : 1.0
// ============================================================================
module codebook_fetch_arbiter
    import pvr_vram_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int MAX_OUT   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cb_wait,
    input  logic [VRAM_AW-1:0] cb_base,
    output logic               cb_valid,
    output logic [VRAM_DW-1:0] cb_dout,
    input  logic               tex_req,
    input  logic [VRAM_AW-1:0] tex_addr,
    output logic               tex_ack,
    output logic               tex_valid,
    output logic [VRAM_DW-1:0] tex_dout,
    output logic               vram_rd,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [LEN_W-1:0]   vram_len,
    input  logic               vram_busy,
    input  logic               vram_valid,
    input  logic [VRAM_DW-1:0] vram_din,
    output logic               busy
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    arb_state_t       r_state;
    logic             r_cb_wait_q;
    logic             r_arm_pend;
    logic             r_cb_armed;
    logic [8:0]       r_cb_issued;
    logic             r_last_cb;
    logic [CNT_W-1:0] r_cb_out;
    logic [LEN_W-1:0] r_beat;

    owner_entry_t     w_head;
    owner_entry_t     w_push_entry;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_beat;
    logic             w_pop;
    logic             w_can_issue;
    logic             w_cb_rise;
    logic             w_arm_req;
    logic             w_arm;
    logic             w_cb_left;
    logic             w_cb_pend;
    logic             w_tex_pend;
    logic             w_unused_lsbs;

    assign w_unused_lsbs = ^{cb_base[2:0], tex_addr[2:0]};

    assign w_accept     = vram_rd && !vram_busy;
    assign w_beat       = vram_valid && !w_empty;
    assign w_pop        = w_beat && ((r_beat + 5'd1) == w_head.len);
    assign w_can_issue  = !w_full || w_pop;
    assign w_push_entry = '{owner: (r_state == TEX_ISSUE) ? OWN_TEX : OWN_CB, len: vram_len};

    // A new fill restarts the word counter, so it waits until no old CB burst
    // is queued or being offered; CB selection is held off meanwhile.
    assign w_cb_rise  = cb_wait && !r_cb_wait_q;
    assign w_arm_req  = w_cb_rise || r_arm_pend;
    assign w_arm      = w_arm_req && (r_cb_out == '0) && (r_state != CB_ISSUE);
    assign w_cb_left  = r_cb_armed && (r_cb_issued < 9'(CB_WORDS));
    assign w_cb_pend  = w_cb_left && !w_arm_req;
    // The registered ack is still high the cycle after issue; mask the held request.
    assign w_tex_pend = tex_req && !tex_ack;

    assign busy = w_cb_left || !w_empty || vram_rd;

    vram_owner_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH ($bits(owner_entry_t))
    ) u_owner_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_accept),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cb_wait_q <= 1'b0;
            r_arm_pend  <= 1'b0;
            r_cb_armed  <= 1'b0;
            r_cb_issued <= '0;
            r_last_cb   <= 1'b0;
            r_cb_out    <= '0;
            r_beat      <= '0;
            vram_rd     <= 1'b0;
            vram_addr   <= '0;
            vram_len    <= '0;
            tex_ack     <= 1'b0;
            cb_valid    <= 1'b0;
            cb_dout     <= '0;
            tex_valid   <= 1'b0;
            tex_dout    <= '0;
        end else begin
            r_cb_wait_q <= cb_wait;
            if (w_arm) begin
                r_arm_pend  <= 1'b0;
                r_cb_armed  <= 1'b1;
                r_cb_issued <= '0;
            end else if (w_cb_rise) begin
                r_arm_pend <= 1'b1;
            end

            tex_ack <= w_accept && (r_state == TEX_ISSUE);
            case (r_state)
                IDLE: begin
                    if (w_can_issue) begin
                        if (w_cb_pend && (!w_tex_pend || !r_last_cb)) begin
                            r_state   <= CB_ISSUE;
                            vram_rd   <= 1'b1;
                            vram_addr <= {cb_base[22:3], 3'b000} + {11'd0, r_cb_issued, 3'b000};
                            vram_len  <= LEN_W'(BURST_LEN);
                        end else if (w_tex_pend) begin
                            r_state   <= TEX_ISSUE;
                            vram_rd   <= 1'b1;
                            vram_addr <= {tex_addr[22:3], 3'b000};
                            vram_len  <= 5'd1;
                        end
                    end
                end
                CB_ISSUE, TEX_ISSUE: begin
                    if (w_accept) begin
                        vram_rd   <= 1'b0;
                        r_state   <= IDLE;
                        r_last_cb <= (r_state == CB_ISSUE);
                        if (r_state == CB_ISSUE) begin
                            r_cb_issued <= r_cb_issued + 9'(BURST_LEN);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    vram_rd <= 1'b0;
                end
            endcase

            if ((w_accept && r_state == CB_ISSUE) && !(w_pop && w_head.owner == OWN_CB)) begin
                r_cb_out <= r_cb_out + 1'b1;
            end else if (!(w_accept && r_state == CB_ISSUE) && (w_pop && w_head.owner == OWN_CB)) begin
                r_cb_out <= r_cb_out - 1'b1;
            end

            if (w_beat) begin
                r_beat <= w_pop ? '0 : r_beat + 5'd1;
            end

            // CB beats are still consumed while cb_wait is low, just not presented.
            cb_valid  <= w_beat && (w_head.owner == OWN_CB) && cb_wait;
            tex_valid <= w_beat && (w_head.owner == OWN_TEX);
            if (w_beat && (w_head.owner == OWN_CB)) begin
                cb_dout <= vram_din;
            end
            if (w_beat && (w_head.owner == OWN_TEX)) begin
                tex_dout <= vram_din;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_codebook_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_codebook_fetch_arbiter
// Brief    : Directed bench with a 2-cycle in-order VRAM model.
// Revision : 1.0
// ============================================================================
module tb_codebook_fetch_arbiter;

    logic        clock;
    logic        reset;
    logic        cb_wait;
    logic [22:0] cb_base;
    logic        cb_valid;
    logic [63:0] cb_dout;
    logic        tex_req;
    logic [22:0] tex_addr;
    logic        tex_ack;
    logic        tex_valid;
    logic [63:0] tex_dout;
    logic        vram_rd;
    logic [22:0] vram_addr;
    logic [4:0]  vram_len;
    logic        vram_busy;
    logic        vram_valid;
    logic [63:0] vram_din;
    logic        busy;

    int checks = 0;
    int errors = 0;

    codebook_fetch_arbiter #(.BURST_LEN(8), .MAX_OUT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .cb_wait    (cb_wait),
        .cb_base    (cb_base),
        .cb_valid   (cb_valid),
        .cb_dout    (cb_dout),
        .tex_req    (tex_req),
        .tex_addr   (tex_addr),
        .tex_ack    (tex_ack),
        .tex_valid  (tex_valid),
        .tex_dout   (tex_dout),
        .vram_rd    (vram_rd),
        .vram_addr  (vram_addr),
        .vram_len   (vram_len),
        .vram_busy  (vram_busy),
        .vram_valid (vram_valid),
        .vram_din   (vram_din),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] wdata(input logic [22:0] a);
        return {16'hA5C3, 25'd0, a};
    endfunction

    // VRAM model: logs accepted requests, returns words in order 2 cycles later.
    logic [22:0] log_addr [$];
    logic [4:0]  log_len  [$];
    logic [22:0] q_addr   [$];
    int          q_rdy    [$];
    int          cyc  = 0;
    bit          hold = 1'b0;

    initial begin
        vram_valid = 1'b0;
        vram_din   = '0;
        forever begin
            @(posedge clock);
            cyc++;
            if (vram_rd && !vram_busy && !reset) begin
                log_addr.push_back(vram_addr);
                log_len.push_back(vram_len);
                for (int j = 0; j < int'(vram_len); j++) begin
                    q_addr.push_back(vram_addr + 23'(8 * j));
                    q_rdy.push_back(cyc + 1);
                end
            end
            @(negedge clock);
            if (!hold && q_addr.size() > 0 && q_rdy[0] <= cyc) begin
                vram_valid = 1'b1;
                vram_din   = wdata(q_addr.pop_front());
                void'(q_rdy.pop_front());
            end else begin
                vram_valid = 1'b0;
                vram_din   = '0;
            end
        end
    end

    // Output monitor: CB beats checked against the expected word sequence.
    logic [22:0] exp_base = '0;
    int          cb_cnt   = 0;
    int          cb_bad   = 0;
    int          tex_cnt  = 0;
    int          ack_cnt  = 0;
    logic [63:0] tex_last = '0;

    initial begin
        forever begin
            @(negedge clock);
            if (cb_valid) begin
                if (cb_dout !== wdata(exp_base + 23'(8 * cb_cnt))) cb_bad++;
                cb_cnt++;
            end
            if (tex_valid) begin
                tex_last = tex_dout;
                tex_cnt++;
            end
            if (tex_ack) ack_cnt++;
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fill(input string tag);
        int k = 0;
        while (!(cb_cnt >= 256 && !busy && q_addr.size() == 0) && k < 3000) begin
            step();
            k++;
        end
        chk(tag, (k < 3000), 1);
    endtask

    task automatic wait_ack(input string tag, input int base);
        int k = 0;
        while (ack_cnt == base && k < 500) begin
            step();
            k++;
        end
        chk(tag, (k < 500), 1);
    endtask

    task automatic wait_quiet(input string tag);
        int k = 0;
        while ((busy || q_addr.size() != 0) && k < 500) begin
            step();
            k++;
        end
        chk(tag, (k < 500), 1);
    endtask

    initial begin
        int          n0;
        int          nbad;
        int          k;
        int          nv;
        bit          stable;
        logic [22:0] a;
        logic [4:0]  l;
        logic [22:0] t6 [4];

        reset = 1'b1; cb_wait = 1'b0; cb_base = '0; tex_req = 1'b0;
        tex_addr = '0; vram_busy = 1'b0;
        repeat (3) step();
        chk("rst_vram_rd", vram_rd, 0);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_cb_valid", cb_valid, 0);
        chk("rst_tex_valid", tex_valid, 0);
        chk("rst_tex_ack", tex_ack, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (2) step();

        // 1: plain fill from 0x100000.
        exp_base = 23'h100000; cb_base = 23'h100000; cb_cnt = 0; cb_bad = 0;
        n0 = log_addr.size();
        cb_wait = 1'b1;
        repeat (2) step();
        chk("t1_busy_high", busy, 1);
        wait_fill("t1_fill_done");
        step();
        chk("t1_cb_beats", cb_cnt, 256);
        chk("t1_cb_order_errs", cb_bad, 0);
        chk("t1_req_count", log_addr.size() - n0, 32);
        nbad = 0;
        for (int i = 0; i < 32; i++) begin
            if (log_addr[n0 + i] !== 23'h100000 + 23'(64 * i) || log_len[n0 + i] !== 5'd8) nbad++;
        end
        chk("t1_req_addr_len_errs", nbad, 0);
        chk("t1_last_addr", log_addr[n0 + 31], 23'h1007C0);
        chk("t1_busy_low", busy, 0);
        cb_wait = 1'b0;
        repeat (3) step();

        // 2: texel request slotted after the CB burst on offer.
        exp_base = 23'h180000; cb_base = 23'h180000; cb_cnt = 0; cb_bad = 0;
        tex_cnt = 0; ack_cnt = 0;
        n0 = log_addr.size();
        cb_wait = 1'b1;
        k = 0;
        while (!(vram_rd && log_addr.size() - n0 >= 3) && k < 500) begin step(); k++; end
        chk("t2_reach_burst", (k < 500), 1);
        nv = log_addr.size();
        tex_addr = 23'h002008; tex_req = 1'b1;
        wait_ack("t2_ack_wait", 0);
        tex_req = 1'b0;
        wait_fill("t2_fill_done");
        step();
        chk("t2_cb_before_tex_len", log_len[nv], 8);
        chk("t2_cb_before_tex_addr", log_addr[nv], 23'h180000 + 23'(64 * (nv - n0)));
        chk("t2_tex_addr", log_addr[nv + 1], 23'h002008);
        chk("t2_tex_len", log_len[nv + 1], 1);
        chk("t2_ack_count", ack_cnt, 1);
        chk("t2_tex_valid_count", tex_cnt, 1);
        chk("t2_tex_data", tex_last, wdata(23'h002008));
        chk("t2_cb_beats", cb_cnt, 256);
        chk("t2_cb_order_errs", cb_bad, 0);
        chk("t2_req_count", log_addr.size() - n0, 33);
        cb_wait = 1'b0;
        repeat (3) step();

        // 3: request held under vram_busy.
        tex_cnt = 0; ack_cnt = 0;
        vram_busy = 1'b1;
        tex_addr = 23'h000100; tex_req = 1'b1;
        k = 0;
        while (!vram_rd && k < 20) begin step(); k++; end
        chk("t3_rd_raised", vram_rd, 1);
        a = vram_addr; l = vram_len; n0 = log_addr.size();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!vram_rd || vram_addr !== a || vram_len !== l) stable = 1'b0;
        end
        chk("t3_stable", stable, 1);
        chk("t3_addr", a, 23'h000100);
        chk("t3_len", l, 1);
        chk("t3_no_accept", log_addr.size() - n0, 0);
        vram_busy = 1'b0;
        wait_ack("t3_ack_wait", 0);
        tex_req = 1'b0;
        wait_quiet("t3_quiet");
        chk("t3_one_accept", log_addr.size() - n0, 1);
        chk("t3_one_return", tex_cnt, 1);
        chk("t3_tex_data", tex_last, wdata(23'h000100));

        // 4: returns withheld, outstanding limit of 4.
        exp_base = 23'h200000; cb_base = 23'h200000; cb_cnt = 0; cb_bad = 0;
        hold = 1'b1;
        n0 = log_addr.size();
        cb_wait = 1'b1;
        repeat (40) step();
        chk("t4_four_accepts", log_addr.size() - n0, 4);
        chk("t4_rd_low_full", vram_rd, 0);
        hold = 1'b0;
        nv = 0; k = 0;
        while (nv < 8 && k < 100) begin
            step();
            k++;
            if (cb_valid) nv++;
        end
        chk("t4_first_burst_beats", nv, 8);
        chk("t4_fifth_req_raised", vram_rd, 1);
        chk("t4_still_four", log_addr.size() - n0, 4);
        step();
        chk("t4_fifth_accept", log_addr.size() - n0, 5);
        wait_fill("t4_fill_done");
        step();
        chk("t4_cb_beats", cb_cnt, 256);
        chk("t4_cb_order_errs", cb_bad, 0);
        cb_wait = 1'b0;
        repeat (3) step();

        // 5: reset at the 100th CB beat, then restart.
        exp_base = 23'h300000; cb_base = 23'h300000; cb_cnt = 0; cb_bad = 0;
        cb_wait = 1'b1;
        nv = 0; k = 0;
        while (nv < 100 && k < 1000) begin
            step();
            k++;
            if (cb_valid) nv++;
        end
        chk("t5_reach_100", nv, 100);
        reset = 1'b1;
        #1;
        chk("t5_rst_cb_valid", cb_valid, 0);
        chk("t5_rst_cb_dout", cb_dout, 0);
        chk("t5_rst_vram_rd", vram_rd, 0);
        chk("t5_rst_vram_len", vram_len, 0);
        chk("t5_rst_busy", busy, 0);
        cb_wait = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        n0 = log_addr.size();
        wait_quiet("t5_drain");
        chk("t5_stale_dropped", cb_cnt, 100);
        chk("t5_no_new_req", log_addr.size() - n0, 0);
        cb_cnt = 0; cb_bad = 0;
        cb_wait = 1'b1;
        wait_fill("t5_refill_done");
        step();
        chk("t5_restart_addr", log_addr[n0], 23'h300000);
        chk("t5_restart_len", log_len[n0], 8);
        chk("t5_cb_beats", cb_cnt, 256);
        chk("t5_cb_order_errs", cb_bad, 0);

        // 6: texel-only traffic with cb_wait still high after the fill.
        t6[0] = 23'h000000; t6[1] = 23'h7FFFF8; t6[2] = 23'h000000; t6[3] = 23'h7FFFF8;
        cb_cnt = 0; tex_cnt = 0; ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tex_addr = t6[i]; tex_req = 1'b1;
            wait_ack("t6_ack_wait", i);
            tex_req = 1'b0;
            wait_quiet("t6_quiet");
            chk("t6_tex_count", tex_cnt, i + 1);
            chk("t6_tex_data", tex_last, wdata(t6[i]));
            chk("t6_req_addr", log_addr[log_addr.size() - 1], t6[i]);
            chk("t6_req_len", log_len[log_len.size() - 1], 1);
        end
        chk("t6_no_cb_valid", cb_cnt, 0);
        cb_wait = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
